// File: rtl/exec_stage_pipe.sv
// exec_stage_pipe: pipelined execute stage.
// Takes one decoded op per cycle over valid/ready, computes ALU / set-condition /
// SLBI results, resolves branches and jumps into a registered one-cycle redirect,
// and holds results in an EX/MEM register with backpressure. MUL runs on an
// iterative shift-add unit that holds the stage for WIDTH cycles.
module exec_stage_pipe #(
    parameter int WIDTH  = 16,
    parameter int DISP_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_a,
    input  logic [WIDTH-1:0]  in_b,
    input  logic [3:0]        in_op,
    input  logic [2:0]        in_br,
    input  logic [DISP_W-1:0] in_disp,
    input  logic [WIDTH-1:0]  in_pc_inc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_result,
    output logic              out_err,
    output logic              redirect_valid,
    output logic [WIDTH-1:0]  redirect_pc,
    output logic              busy
);

    localparam int SH_W = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_XOR   = 4'd2;
    localparam logic [3:0] OP_ANDN  = 4'd3;
    localparam logic [3:0] OP_ROL   = 4'd4;
    localparam logic [3:0] OP_SLL   = 4'd5;
    localparam logic [3:0] OP_ROR   = 4'd6;
    localparam logic [3:0] OP_SRL   = 4'd7;
    localparam logic [3:0] OP_SEQ   = 4'd8;
    localparam logic [3:0] OP_SLT   = 4'd9;
    localparam logic [3:0] OP_SLE   = 4'd10;
    localparam logic [3:0] OP_SCO   = 4'd11;
    localparam logic [3:0] OP_SLBI  = 4'd12;
    localparam logic [3:0] OP_PASSB = 4'd13;
    localparam logic [3:0] OP_MUL   = 4'd14;
    localparam logic [3:0] OP_ILL   = 4'd15;

    localparam logic [2:0] BR_BEQZ = 3'd1;
    localparam logic [2:0] BR_BNEZ = 3'd2;
    localparam logic [2:0] BR_BLTZ = 3'd3;
    localparam logic [2:0] BR_BGEZ = 3'd4;
    localparam logic [2:0] BR_JMP  = 3'd5;
    localparam logic [2:0] BR_JR   = 3'd6;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    // Zero-extends a single condition bit to a full datapath word.
    function automatic logic [WIDTH-1:0] zext1(input logic bit_v);
        return {{(WIDTH-1){1'b0}}, bit_v};
    endfunction

    state_t            state_r;
    logic              busy_r;
    logic [WIDTH-1:0]  acc_r;
    logic [WIDTH-1:0]  mcand_r;
    logic [WIDTH-1:0]  mplier_r;
    logic [SH_W-1:0]   cnt_r;

    logic              out_valid_r;
    logic [WIDTH-1:0]  out_result_r;
    logic              out_err_r;
    logic              redirect_valid_r;
    logic [WIDTH-1:0]  redirect_pc_r;

    logic              out_free_s;
    logic              in_ready_s;
    logic              accept_s;
    logic              is_mul_s;
    logic [SH_W-1:0]   sh_s;
    logic [WIDTH:0]    add_sum_s;
    logic [WIDTH-1:0]  rol_s;
    logic [WIDTH-1:0]  ror_s;
    logic [WIDTH-1:0]  slbi_s;
    logic [WIDTH-1:0]  alu_result_s;
    logic              alu_err_s;
    logic [WIDTH-1:0]  disp_full_s;
    logic [WIDTH-1:0]  disp_short_s;
    logic              taken_s;
    logic [WIDTH-1:0]  target_s;
    logic [WIDTH-1:0]  mul_addend_s;
    logic [WIDTH-1:0]  mul_sum_s;
    logic              mul_last_s;
    logic              mul_done_s;

    // The output slot can take a new value when empty or being drained this cycle.
    assign out_free_s = !out_valid_r || out_ready;
    assign in_ready_s = (state_r == ST_IDLE) && out_free_s && !flush && !rst;
    assign accept_s   = in_valid && in_ready_s;
    assign is_mul_s   = (in_op == OP_MUL);

    // Shared datapath pieces feeding the ALU select.
    assign sh_s      = in_b[SH_W-1:0];
    assign add_sum_s = {1'b0, in_a} + {1'b0, in_b};
    assign rol_s     = (in_a << sh_s) | (in_a >> (WIDTH - int'(sh_s)));
    assign ror_s     = (in_a >> sh_s) | (in_a << (WIDTH - int'(sh_s)));
    assign slbi_s    = {in_a[WIDTH-9:0], 8'h00} | {{(WIDTH-8){1'b0}}, in_b[7:0]};

    // ALU result select; MUL is produced by the iterative unit instead.
    always_comb begin
        alu_result_s = {WIDTH{1'b0}};
        alu_err_s    = 1'b0;
        case (in_op)
            OP_ADD:   alu_result_s = add_sum_s[WIDTH-1:0];
            OP_SUB:   alu_result_s = in_b - in_a;
            OP_XOR:   alu_result_s = in_a ^ in_b;
            OP_ANDN:  alu_result_s = in_a & ~in_b;
            OP_ROL:   alu_result_s = rol_s;
            OP_SLL:   alu_result_s = in_a << sh_s;
            OP_ROR:   alu_result_s = ror_s;
            OP_SRL:   alu_result_s = in_a >> sh_s;
            OP_SEQ:   alu_result_s = zext1(in_a == in_b);
            OP_SLT:   alu_result_s = zext1($signed(in_a) < $signed(in_b));
            OP_SLE:   alu_result_s = zext1($signed(in_a) <= $signed(in_b));
            OP_SCO:   alu_result_s = zext1(add_sum_s[WIDTH]);
            OP_SLBI:  alu_result_s = slbi_s;
            OP_PASSB: alu_result_s = in_b;
            OP_MUL:   alu_result_s = {WIDTH{1'b0}};
            OP_ILL:   alu_err_s    = 1'b1;
            default: begin
                alu_result_s = {WIDTH{1'b0}};
                alu_err_s    = 1'b0;
            end
        endcase
    end

    // Sign-extended displacements: full width for JMP, low byte for branches and JR.
    assign disp_full_s  = WIDTH'($signed(in_disp));
    assign disp_short_s = WIDTH'($signed(in_disp[7:0]));

    // Branch/jump resolution and target address.
    always_comb begin
        taken_s  = 1'b0;
        target_s = in_pc_inc + disp_short_s;
        case (in_br)
            BR_BEQZ: taken_s = (in_a == {WIDTH{1'b0}});
            BR_BNEZ: taken_s = (in_a != {WIDTH{1'b0}});
            BR_BLTZ: taken_s = in_a[WIDTH-1];
            BR_BGEZ: taken_s = !in_a[WIDTH-1];
            BR_JMP: begin
                taken_s  = 1'b1;
                target_s = in_pc_inc + disp_full_s;
            end
            BR_JR: begin
                taken_s  = 1'b1;
                target_s = in_a + disp_short_s;
            end
            default: taken_s = 1'b0;
        endcase
    end

    // One shift-add step; the last step completes only if the output slot is free.
    assign mul_addend_s = mplier_r[0] ? mcand_r : {WIDTH{1'b0}};
    assign mul_sum_s    = acc_r + mul_addend_s;
    assign mul_last_s   = (cnt_r == SH_W'(WIDTH - 1));
    assign mul_done_s   = (state_r == ST_MUL) && mul_last_s && out_free_s;

    // Control FSM and multiplier datapath; flush and rst abort any multiply.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            busy_r   <= 1'b0;
            acc_r    <= {WIDTH{1'b0}};
            mcand_r  <= {WIDTH{1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            cnt_r    <= {SH_W{1'b0}};
        end else if (flush) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            cnt_r   <= {SH_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s && is_mul_s) begin
                        state_r  <= ST_MUL;
                        busy_r   <= 1'b1;
                        acc_r    <= {WIDTH{1'b0}};
                        mcand_r  <= in_a;
                        mplier_r <= in_b;
                        cnt_r    <= {SH_W{1'b0}};
                    end
                end
                ST_MUL: begin
                    if (!mul_last_s) begin
                        acc_r    <= mul_sum_s;
                        mcand_r  <= {mcand_r[WIDTH-2:0], 1'b0};
                        mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
                        cnt_r    <= cnt_r + SH_W'(1);
                    end else if (mul_done_s) begin
                        acc_r   <= mul_sum_s;
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // EX/MEM register and redirect pulse; a new result may load in the same cycle the old one drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r      <= 1'b0;
            out_result_r     <= {WIDTH{1'b0}};
            out_err_r        <= 1'b0;
            redirect_valid_r <= 1'b0;
            redirect_pc_r    <= {WIDTH{1'b0}};
        end else if (flush) begin
            out_valid_r      <= 1'b0;
            out_result_r     <= {WIDTH{1'b0}};
            out_err_r        <= 1'b0;
            redirect_valid_r <= 1'b0;
        end else begin
            redirect_valid_r <= 1'b0;
            if (accept_s && !is_mul_s) begin
                out_valid_r  <= 1'b1;
                out_result_r <= alu_result_s;
                out_err_r    <= alu_err_s;
                if (taken_s) begin
                    redirect_valid_r <= 1'b1;
                    redirect_pc_r    <= target_s;
                end
            end else if (mul_done_s) begin
                out_valid_r  <= 1'b1;
                out_result_r <= mul_sum_s;
                out_err_r    <= 1'b0;
            end else if (out_valid_r && out_ready) begin
                out_valid_r  <= 1'b0;
                out_result_r <= {WIDTH{1'b0}};
                out_err_r    <= 1'b0;
            end
        end
    end

    assign in_ready       = in_ready_s;
    assign out_valid      = out_valid_r;
    assign out_result     = out_result_r;
    assign out_err        = out_err_r;
    assign redirect_valid = redirect_valid_r;
    assign redirect_pc    = redirect_pc_r;
    assign busy           = busy_r;

endmodule

// File: tb/tb_exec_stage_pipe.sv
// tb_exec_stage_pipe: directed vectors with literal expectations plus a
// behavioural scoreboard that predicts every transferred result and redirect.
module tb_exec_stage_pipe;

    localparam int W = 16;
    localparam int D = 11;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic [3:0]    in_op;
    logic [2:0]    in_br;
    logic [D-1:0]  in_disp;
    logic [W-1:0]  in_pc_inc;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_result;
    logic          out_err;
    logic          redirect_valid;
    logic [W-1:0]  redirect_pc;
    logic          busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic [W:0]   exp_q[$];
    logic [W-1:0] red_q[$];

    always #5 clk = ~clk;

    exec_stage_pipe #(.WIDTH(W), .DISP_W(D)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_br(in_br),
        .in_disp(in_disp), .in_pc_inc(in_pc_inc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_err(out_err),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .busy(busy)
    );

    task automatic chk1(input string name, input logic got, input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0b expected %0b", name, got, exp);
        end
    endtask

    task automatic chkw(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference result {err, value} from the op table, using integer arithmetic.
    function automatic logic [W:0] model_out(input logic [3:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic [W-1:0] r;
        logic         e;
        int           sa;
        int           sb;
        int           amt;
        r   = 16'h0000;
        e   = 1'b0;
        sa  = int'($signed(a));
        sb  = int'($signed(b));
        amt = int'(b[3:0]);
        case (op)
            4'd0:  r = W'(int'(a) + int'(b));
            4'd1:  r = W'(int'(b) - int'(a));
            4'd2:  r = a ^ b;
            4'd3:  r = a & ~b;
            4'd4: begin
                r = a;
                for (int i = 0; i < amt; i++) r = {r[W-2:0], r[W-1]};
            end
            4'd5:  r = W'(longint'(a) * (longint'(1) << amt));
            4'd6: begin
                r = a;
                for (int i = 0; i < amt; i++) r = {r[0], r[W-1:1]};
            end
            4'd7:  r = W'(int'(a) / (1 << amt));
            4'd8:  r = (a == b) ? 16'd1 : 16'd0;
            4'd9:  r = (sa < sb) ? 16'd1 : 16'd0;
            4'd10: r = (sa <= sb) ? 16'd1 : 16'd0;
            4'd11: r = ((int'(a) + int'(b)) > 65535) ? 16'd1 : 16'd0;
            4'd12: r = W'(int'(a) * 256 + int'(b[7:0]));
            4'd13: r = b;
            4'd14: r = W'(longint'(a) * longint'(b));
            default: begin
                r = 16'h0000;
                e = 1'b1;
            end
        endcase
        return {e, r};
    endfunction

    function automatic logic model_taken(input logic [2:0] br, input logic [W-1:0] a);
        case (br)
            3'd1: return (a == 16'h0000);
            3'd2: return (a != 16'h0000);
            3'd3: return (int'($signed(a)) < 0);
            3'd4: return (int'($signed(a)) >= 0);
            3'd5: return 1'b1;
            3'd6: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [W-1:0] model_target(input logic [2:0] br, input logic [W-1:0] a,
                                                  input logic [D-1:0] disp, input logic [W-1:0] pc);
        int d8;
        int d11;
        d8  = int'(disp[7:0]);
        d11 = int'(disp);
        if (d8 > 127) d8 = d8 - 256;
        if (d11 > 1023) d11 = d11 - 2048;
        case (br)
            3'd5:    return W'(int'(pc) + d11);
            3'd6:    return W'(int'(a) + d8);
            default: return W'(int'(pc) + d8);
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one op, wait (bounded) for acceptance, record model expectations.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] br, input logic [D-1:0] disp, input logic [W-1:0] pc);
        int t;
        t         = 0;
        in_valid  = 1'b1;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        in_br     = br;
        in_disp   = disp;
        in_pc_inc = pc;
        @(negedge clk);
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            chk1("accept_timeout", in_ready, 1'b1);
        end else begin
            exp_q.push_back(model_out(op, a, b));
            if (op != 4'd14 && model_taken(br, a)) red_q.push_back(model_target(br, a, disp, pc));
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic issue_chk(input string name, input logic [3:0] op, input logic [W-1:0] a,
                             input logic [W-1:0] b, input logic [W-1:0] exp_r, input logic exp_e);
        issue(op, a, b, 3'd0, 11'h000, 16'h0000);
        @(negedge clk);
        chk1({name, "_valid"}, out_valid, 1'b1);
        chkw({name, "_result"}, out_result, exp_r);
        chk1({name, "_err"}, out_err, exp_e);
        step();
    endtask

    task automatic issue_br(input string name, input logic [2:0] br, input logic [W-1:0] a,
                            input logic [D-1:0] disp, input logic [W-1:0] pc,
                            input logic exp_t, input logic [W-1:0] exp_pc);
        issue(4'd13, a, 16'h0000, br, disp, pc);
        @(negedge clk);
        chk1({name, "_redirect"}, redirect_valid, exp_t);
        if (exp_t) chkw({name, "_target"}, redirect_pc, exp_pc);
        step();
        @(negedge clk);
        chk1({name, "_pulse_end"}, redirect_valid, 1'b0);
        step();
    endtask

    // Runs a MUL and checks busy/in_ready for WIDTH cycles and the result after.
    task automatic mul_run(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] exp_r);
        issue(4'd14, a, b, 3'd5, 11'h004, 16'h0100);
        for (int k = 0; k < W; k++) begin
            @(negedge clk);
            chk1({name, "_busy"}, busy, 1'b1);
            chk1({name, "_in_ready"}, in_ready, 1'b0);
            chk1({name, "_early_valid"}, out_valid, 1'b0);
            step();
        end
        @(negedge clk);
        chk1({name, "_valid"}, out_valid, 1'b1);
        chkw({name, "_result"}, out_result, exp_r);
        chk1({name, "_busy_done"}, busy, 1'b0);
    endtask

    // Scoreboard: every transfer and every redirect must match the model, in order.
    always @(negedge clk) begin
        logic [W:0] e;
        if (!rst && !flush) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk1("sb_unexpected_out", out_valid, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    chkw("sb_result", out_result, e[W-1:0]);
                    chk1("sb_err", out_err, e[W]);
                end
            end
            if (redirect_valid) begin
                chk1("sb_redirect_with_valid", out_valid, 1'b1);
                if (red_q.size() == 0) begin
                    chk1("sb_unexpected_redirect", redirect_valid, 1'b0);
                end else begin
                    chkw("sb_redirect_pc", redirect_pc, red_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pat;
        int         seen;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_a      = 16'h0000;
        in_b      = 16'h0000;
        in_op     = 4'd0;
        in_br     = 3'd0;
        in_disp   = 11'h000;
        in_pc_inc = 16'h0000;
        out_ready = 1'b1;
        @(negedge clk);
        chk1("rst_in_ready", in_ready, 1'b0);
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        chk1("reset_out_valid", out_valid, 1'b0);
        chkw("reset_out_result", out_result, 16'h0000);
        chk1("reset_out_err", out_err, 1'b0);
        chk1("reset_redirect_valid", redirect_valid, 1'b0);
        chkw("reset_redirect_pc", redirect_pc, 16'h0000);
        chk1("reset_busy", busy, 1'b0);
        chk1("idle_in_ready", in_ready, 1'b1);
        step();

        issue_chk("add_ovf",   4'd0,  16'h7FFF, 16'h0001, 16'h8000, 1'b0);
        issue_chk("sco_zero",  4'd11, 16'h7FFF, 16'h0001, 16'h0000, 1'b0);
        issue_chk("slt_neg",   4'd9,  16'h8000, 16'h0001, 16'h0001, 1'b0);
        issue_chk("sub_pos",   4'd1,  16'h0003, 16'h000A, 16'h0007, 1'b0);
        issue_chk("sub_neg",   4'd1,  16'h0005, 16'h0003, 16'hFFFE, 1'b0);
        issue_chk("xor",       4'd2,  16'hF0F0, 16'hFF00, 16'h0FF0, 1'b0);
        issue_chk("andn",      4'd3,  16'hF0F0, 16'hFF00, 16'h00F0, 1'b0);
        issue_chk("rol_wrap",  4'd4,  16'h8001, 16'h0001, 16'h0003, 1'b0);
        issue_chk("rol_low4",  4'd4,  16'h1234, 16'h0014, 16'h2341, 1'b0);
        issue_chk("sll_max",   4'd5,  16'h0001, 16'h000F, 16'h8000, 1'b0);
        issue_chk("ror",       4'd6,  16'h0001, 16'h0004, 16'h1000, 1'b0);
        issue_chk("srl_max",   4'd7,  16'h8000, 16'h000F, 16'h0001, 1'b0);
        issue_chk("seq_eq",    4'd8,  16'h1234, 16'h1234, 16'h0001, 1'b0);
        issue_chk("seq_ne",    4'd8,  16'h1234, 16'h1235, 16'h0000, 1'b0);
        issue_chk("slt_ovf",   4'd9,  16'h7FFF, 16'h8000, 16'h0000, 1'b0);
        issue_chk("sle_eq",    4'd10, 16'h8000, 16'h8000, 16'h0001, 1'b0);
        issue_chk("sle_gt",    4'd10, 16'h0001, 16'hFFFF, 16'h0000, 1'b0);
        issue_chk("sco_one",   4'd11, 16'hFFFF, 16'h0001, 16'h0001, 1'b0);
        issue_chk("slbi",      4'd12, 16'h0012, 16'h5634, 16'h1234, 1'b0);
        issue_chk("slbi_trunc",4'd12, 16'hABCD, 16'h00EF, 16'hCDEF, 1'b0);
        issue_chk("passb",     4'd13, 16'h0000, 16'hBEEF, 16'hBEEF, 1'b0);
        issue_chk("illegal",   4'd15, 16'h0001, 16'h0002, 16'h0000, 1'b1);

        issue_br("beqz_t",  3'd1, 16'h0000, 11'h0FE, 16'h0100, 1'b1, 16'h00FE);
        issue_br("beqz_nt", 3'd1, 16'h0005, 11'h0FE, 16'h0100, 1'b0, 16'h0000);
        issue_br("bnez_t",  3'd2, 16'h0005, 11'h010, 16'h0100, 1'b1, 16'h0110);
        issue_br("bltz_t",  3'd3, 16'h8000, 11'h080, 16'h0200, 1'b1, 16'h0180);
        issue_br("bgez_nt", 3'd4, 16'h8000, 11'h010, 16'h0200, 1'b0, 16'h0000);
        issue_br("bgez_t",  3'd4, 16'h7FFF, 11'h07F, 16'h0200, 1'b1, 16'h027F);
        issue_br("jr",      3'd6, 16'h2000, 11'h7FF, 16'h0000, 1'b1, 16'h1FFF);
        issue_br("jmp",     3'd5, 16'h0000, 11'h400, 16'h0010, 1'b1, 16'hFC10);
        issue_br("br_rsvd", 3'd7, 16'h0000, 11'h010, 16'h0100, 1'b0, 16'h0000);

        mul_run("mul_7x9", 16'h0007, 16'h0009, 16'h003F);
        step();
        mul_run("mul_wrap", 16'hFFFF, 16'h0003, 16'hFFFD);
        step();

        out_ready = 1'b0;
        mul_run("mul_held", 16'h0123, 16'h0045, 16'h4E6F);
        for (int k = 0; k < 3; k++) begin
            step();
            @(negedge clk);
            chk1("mul_held_valid", out_valid, 1'b1);
            chkw("mul_held_result", out_result, 16'h4E6F);
            chk1("mul_held_in_ready", in_ready, 1'b0);
        end
        step();
        out_ready = 1'b1;
        step();
        @(negedge clk);
        chk1("mul_held_drained", out_valid, 1'b0);
        step();

        pat = 8'b1110_1001;
        fork
            begin
                issue(4'd0, 16'h0001, 16'h0001, 3'd0, 11'h000, 16'h0000);
                issue(4'd0, 16'h0010, 16'h0002, 3'd0, 11'h000, 16'h0000);
                issue(4'd0, 16'h0100, 16'h0003, 3'd0, 11'h000, 16'h0000);
                issue(4'd0, 16'h1000, 16'h0004, 3'd0, 11'h000, 16'h0000);
                issue(4'd0, 16'hFFFF, 16'h0005, 3'd0, 11'h000, 16'h0000);
            end
            begin
                for (int k = 0; k < 8; k++) begin
                    out_ready = pat[k];
                    step();
                end
                out_ready = 1'b1;
            end
        join
        step();
        step();
        chk1("b2b_drained", (exp_q.size() == 0), 1'b1);

        issue(4'd14, 16'h0005, 16'h0005, 3'd0, 11'h000, 16'h0000);
        step();
        step();
        step();
        step();
        flush    = 1'b1;
        in_valid = 1'b1;
        in_op    = 4'd0;
        in_br    = 3'd0;
        @(negedge clk);
        chk1("flush_in_ready", in_ready, 1'b0);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        void'(exp_q.pop_back());
        @(negedge clk);
        chk1("flush_busy", busy, 1'b0);
        chk1("flush_out_valid", out_valid, 1'b0);
        chk1("flush_in_ready_after", in_ready, 1'b1);
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk1("flush_no_result", (seen == 0), 1'b1);
        step();

        out_ready = 1'b0;
        issue(4'd0, 16'h0001, 16'h0002, 3'd0, 11'h000, 16'h0000);
        @(negedge clk);
        chk1("pre_rst_valid", out_valid, 1'b1);
        step();
        rst = 1'b1;
        @(negedge clk);
        chk1("rst_cycle_in_ready", in_ready, 1'b0);
        step();
        rst = 1'b0;
        exp_q.delete();
        red_q.delete();
        out_ready = 1'b1;
        @(negedge clk);
        chk1("rst_out_valid", out_valid, 1'b0);
        chkw("rst_out_result", out_result, 16'h0000);
        chk1("rst_out_err", out_err, 1'b0);
        chk1("rst_redirect_valid", redirect_valid, 1'b0);
        chkw("rst_redirect_pc", redirect_pc, 16'h0000);
        chk1("rst_busy", busy, 1'b0);
        step();
        step();
        step();

        chk1("queues_empty", (exp_q.size() == 0) && (red_q.size() == 0), 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
